found_reporter: RTL and testbench
=================================

Name: found_reporter

Overview:
- Downstream consumer of the brute-force decoder stage.
- Watches the decoder's FOUND flag and snapshots the matching candidate password the cycle it asserts.
- Converts each base-95 digit of the snapshot to printable ASCII and streams the bytes, most significant digit first, over a valid/ready byte interface (UART TX or host FIFO), then sends a newline terminator.
- The decoder's counter free-runs and cannot stall, so matches arriving while a report is in flight are counted and dropped.

Parameters:
- PASSLEN, 5: number of password digits (bytes) in PASSWD_IN.
- TERM_CHAR, 8'h0A: terminator byte sent after the last digit.
- CNT_W, 16: width of the HIT_CNT and DROP_CNT counters.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- FOUND  in  1  match flag from the decoder; combinational, may be high for one or more consecutive cycles.
- PASSWD_IN  in  8*PASSLEN  candidate digits; byte i at bits [8i+7:8i], byte 0 is the fastest-changing digit; legal digit values 0..94.
- TX_DATA  out  8  ASCII byte.
- TX_VALID  out  1  TX_DATA is valid.
- TX_READY  in  1  sink accepts the byte on a cycle where TX_VALID=1 and TX_READY=1.
- BUSY  out  1  a report is in flight.
- HIT_CNT  out  CNT_W  number of matches captured; saturates at all-ones.
- DROP_CNT  out  CNT_W  number of matches ignored while BUSY; saturates at all-ones.
- ERR  out  1  sticky flag: a captured digit was greater than 94.

Behaviour:
- Reset (async assert, release synchronous to CLK):
  - TX_DATA=0, TX_VALID=0, BUSY=0, HIT_CNT=0, DROP_CNT=0, ERR=0.
  - State returns to IDLE; the snapshot register and digit index are cleared.
  - Reset mid-report aborts the report. No further bytes are emitted and the partial report is not resumed.
- FSM states: IDLE, SEND, TERM.
- IDLE:
  - Transition occurs on a rising edge with FOUND=1.
  - On that edge: latch PASSWD_IN into the snapshot, set digit index to PASSLEN-1, increment HIT_CNT, go to SEND.
  - BUSY and TX_VALID are 1 from the next cycle, so the first byte is presented one cycle after capture.
- SEND:
  - TX_DATA = snapshot byte[index] + 8'h20. If that byte is greater than 94, TX_DATA = 8'h3F ('?') and ERR sets on entry to that byte.
  - On handshake: if index=0, go to TERM; otherwise decrement index.
  - TX_DATA and TX_VALID are held stable while TX_READY=0. TX_VALID never drops without a handshake.
- TERM:
  - TX_DATA=TERM_CHAR, TX_VALID=1.
  - On handshake: go to IDLE; TX_VALID=0 and BUSY=0 on the next cycle.
- Matches while busy:
  - FOUND=1 in SEND or TERM increments DROP_CNT once per cycle high. The snapshot is unchanged.
  - FOUND=1 on the same edge as the TERM handshake counts as a drop, not a capture. Capture is evaluated only when the state is IDLE.
- Multi-cycle FOUND:
  - The first cycle high in IDLE is the capture.
  - Each following cycle high falls in SEND and counts as a drop.
- Throughput: with TX_READY held at 1, a report takes exactly PASSLEN+1 consecutive TX_VALID cycles. Back-to-back reports need at least one IDLE cycle between them.
- Counter rules: both counters saturate and never wrap. ERR clears only on reset.
- Arithmetic: the +8'h20 offset is 8-bit. Legal digits map to 0x20..0x7E. The illegal-digit range check is done before the add.

Test Plan:
- PASSLEN=5, PASSWD_IN bytes[4..0]=21,45,00,5E,10 (hex), one-cycle FOUND, TX_READY=1 -> TX_DATA sequence 41,65,20,7E,30,0A on 6 consecutive cycles starting 1 cycle after FOUND; HIT_CNT=1; BUSY low after the last handshake.
- Same capture, TX_READY toggled 1,0,0,1,... -> TX_DATA/TX_VALID held across stalls; the same 6 bytes in order; no duplicated or skipped bytes.
- FOUND high 4 consecutive cycles, then a 2-cycle pulse during TERM -> HIT_CNT=1, DROP_CNT=5; emitted digits equal the PASSWD_IN of the first FOUND cycle.
- Captured byte 2 = 0x60 -> third emitted byte 0x3F, ERR=1 and stays 1 through a second clean report.
- Assert RST during the third byte with TX_READY=0 -> TX_VALID=0 and all outputs 0 immediately; the next FOUND produces a full fresh report.
- CNT_W=2, 5 separated captures -> HIT_CNT sticks at 3.

Source files
------------

// File: rtl/found_reporter.sv
// found_reporter: snapshots the decoder's matching candidate on FOUND and
// streams it as printable ASCII (most significant digit first) followed by a
// terminator byte over a valid/ready byte interface. Matches arriving while a
// report is in flight are counted and dropped, since the decoder cannot stall.
module found_reporter #(
    parameter int          PASSLEN   = 5,
    parameter logic [7:0]  TERM_CHAR = 8'h0A,
    parameter int          CNT_W     = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   FOUND,
    input  logic [8*PASSLEN-1:0]   PASSWD_IN,
    output logic [7:0]             TX_DATA,
    output logic                   TX_VALID,
    input  logic                   TX_READY,
    output logic                   BUSY,
    output logic [CNT_W-1:0]       HIT_CNT,
    output logic [CNT_W-1:0]       DROP_CNT,
    output logic                   ERR
);

    localparam int               IDX_W   = (PASSLEN > 1) ? $clog2(PASSLEN) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PASSLEN - 1);
    localparam logic [7:0]       MAX_DIG = 8'd94;

    typedef enum logic [1:0] {IDLE, SEND, TERM} state_t;

    state_t                  state_q, state_d;
    logic [8*PASSLEN-1:0]    snap_q, snap_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        hit_q, hit_d;
    logic [CNT_W-1:0]        drop_q, drop_d;
    logic                    err_q, err_d;
    logic                    hs;
    logic [7:0]              cur_byte;

    function automatic logic [7:0] byte_at(input logic [8*PASSLEN-1:0] v,
                                           input logic [IDX_W-1:0]     i);
        return v[int'(i)*8 +: 8];
    endfunction

    // Moore outputs: valid for the whole report, data held while stalled
    assign TX_VALID = (state_q != IDLE);
    assign BUSY     = (state_q != IDLE);
    assign HIT_CNT  = hit_q;
    assign DROP_CNT = drop_q;
    assign ERR      = err_q;
    assign hs       = TX_VALID & TX_READY;
    assign cur_byte = byte_at(snap_q, idx_q);

    // Byte presented to the sink; out-of-range digits show as '?'
    always_comb begin
        TX_DATA = 8'h00;
        case (state_q)
            SEND:    TX_DATA = (cur_byte > MAX_DIG) ? 8'h3F : cur_byte + 8'h20;
            TERM:    TX_DATA = TERM_CHAR;
            default: TX_DATA = 8'h00;
        endcase
    end

    // Next-state: capture only from IDLE, every FOUND cycle elsewhere is a drop
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        idx_d   = idx_q;
        hit_d   = hit_q;
        drop_d  = drop_q;
        case (state_q)
            IDLE: begin
                if (FOUND) begin
                    snap_d  = PASSWD_IN;
                    idx_d   = IDX_TOP;
                    state_d = SEND;
                    if (hit_q != '1) hit_d = hit_q + CNT_W'(1);
                end
            end
            SEND: begin
                if (FOUND && drop_q != '1) drop_d = drop_q + CNT_W'(1);
                if (hs) begin
                    if (idx_q == '0) state_d = TERM;
                    else             idx_d   = idx_q - IDX_W'(1);
                end
            end
            TERM: begin
                if (FOUND && drop_q != '1) drop_d = drop_q + CNT_W'(1);
                if (hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Range check on the raw digit, flagged as that byte comes up
        err_d = err_q | ((state_d == SEND) && (byte_at(snap_d, idx_d) > MAX_DIG));
    end

    // State registers; reset aborts any report in flight
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            snap_q  <= '0;
            idx_q   <= '0;
            hit_q   <= '0;
            drop_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            idx_q   <= idx_d;
            hit_q   <= hit_d;
            drop_q  <= drop_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_found_reporter.sv
// Directed bench for found_reporter: a cycle table for the streaming cases,
// hand-written sequences for reset-abort and counter saturation.
module tb_found_reporter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        FOUND = 1'b0;
    logic [39:0] PASSWD_IN = '0;
    logic        TX_READY = 1'b0;
    logic [7:0]  TX_DATA, TX_DATA2;
    logic        TX_VALID, TX_VALID2, BUSY, BUSY2, ERR, ERR2;
    logic [15:0] HIT_CNT, DROP_CNT;
    logic [1:0]  HIT_CNT2, DROP_CNT2;

    int n_tests = 0;
    int n_fail  = 0;

    found_reporter #(.PASSLEN(5), .TERM_CHAR(8'h0A), .CNT_W(16)) dut (
        .CLK(CLK), .RST(RST), .FOUND(FOUND), .PASSWD_IN(PASSWD_IN),
        .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
        .BUSY(BUSY), .HIT_CNT(HIT_CNT), .DROP_CNT(DROP_CNT), .ERR(ERR)
    );

    // Narrow-counter copy sharing the same stimulus, for saturation checks
    found_reporter #(.PASSLEN(5), .TERM_CHAR(8'h0A), .CNT_W(2)) dut2 (
        .CLK(CLK), .RST(RST), .FOUND(FOUND), .PASSWD_IN(PASSWD_IN),
        .TX_DATA(TX_DATA2), .TX_VALID(TX_VALID2), .TX_READY(TX_READY),
        .BUSY(BUSY2), .HIT_CNT(HIT_CNT2), .DROP_CNT(DROP_CNT2), .ERR(ERR2)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        f;
        logic [39:0] pw;
        logic        r;
        logic        v;
        logic [7:0]  d;
        logic        b;
        logic        e;
    } vec_t;

    vec_t tbl[80];
    int   n_vec = 0;

    localparam logic [39:0] PW1 = 40'h21_45_00_5E_10;
    localparam logic [39:0] PW2 = 40'h01_02_03_04_05;
    localparam logic [39:0] PW3 = 40'h11_22_60_33_44;

    task automatic add(input logic f, input logic [39:0] pw, input logic r,
                       input logic v, input logic [7:0] d, input logic b,
                       input logic e);
        tbl[n_vec] = '{f: f, pw: pw, r: r, v: v, d: d, b: b, e: e};
        n_vec++;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        FOUND = 1'b0;
        TX_READY = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_bytes [6];
        exp_bytes = '{8'h41, 8'h65, 8'h20, 8'h7E, 8'h30, 8'h0A};

        // A: one-cycle FOUND, sink always ready
        add(1, PW1, 1, 0, 8'h00, 0, 0);
        add(0, PW1, 1, 1, 8'h41, 1, 0);
        add(0, PW1, 1, 1, 8'h65, 1, 0);
        add(0, PW1, 1, 1, 8'h20, 1, 0);
        add(0, PW1, 1, 1, 8'h7E, 1, 0);
        add(0, PW1, 1, 1, 8'h30, 1, 0);
        add(0, PW1, 1, 1, 8'h0A, 1, 0);
        add(0, PW1, 1, 0, 8'h00, 0, 0);
        // B: ready pattern 1,0,0,1 repeating; bytes held across stalls
        add(1, PW1, 0, 0, 8'h00, 0, 0);
        add(0, PW1, 1, 1, 8'h41, 1, 0);
        add(0, PW1, 0, 1, 8'h65, 1, 0);
        add(0, PW1, 0, 1, 8'h65, 1, 0);
        add(0, PW1, 1, 1, 8'h65, 1, 0);
        add(0, PW1, 1, 1, 8'h20, 1, 0);
        add(0, PW1, 0, 1, 8'h7E, 1, 0);
        add(0, PW1, 0, 1, 8'h7E, 1, 0);
        add(0, PW1, 1, 1, 8'h7E, 1, 0);
        add(0, PW1, 1, 1, 8'h30, 1, 0);
        add(0, PW1, 0, 1, 8'h0A, 1, 0);
        add(0, PW1, 0, 1, 8'h0A, 1, 0);
        add(0, PW1, 1, 1, 8'h0A, 1, 0);
        add(0, PW1, 0, 0, 8'h00, 0, 0);
        // C: FOUND for 4 cycles (3 drops), then 2 cycles in TERM (2 drops,
        // the second on the TERM handshake edge must not capture)
        add(1, PW1, 1, 0, 8'h00, 0, 0);
        add(1, PW2, 1, 1, 8'h41, 1, 0);
        add(1, PW2, 1, 1, 8'h65, 1, 0);
        add(1, PW2, 1, 1, 8'h20, 1, 0);
        add(0, PW2, 1, 1, 8'h7E, 1, 0);
        add(0, PW2, 1, 1, 8'h30, 1, 0);
        add(1, PW2, 0, 1, 8'h0A, 1, 0);
        add(1, PW2, 1, 1, 8'h0A, 1, 0);
        add(0, PW2, 1, 0, 8'h00, 0, 0);
        add(0, PW2, 1, 0, 8'h00, 0, 0);
        // D: byte 2 = 0x60 is illegal -> '?' and sticky ERR
        add(1, PW3, 1, 0, 8'h00, 0, 0);
        add(0, PW3, 1, 1, 8'h31, 1, 0);
        add(0, PW3, 1, 1, 8'h42, 1, 0);
        add(0, PW3, 1, 1, 8'h3F, 1, 1);
        add(0, PW3, 1, 1, 8'h53, 1, 1);
        add(0, PW3, 1, 1, 8'h64, 1, 1);
        add(0, PW3, 1, 1, 8'h0A, 1, 1);
        add(0, PW3, 1, 0, 8'h00, 0, 1);
        // E: clean report afterwards, ERR stays set
        add(1, PW1, 1, 0, 8'h00, 0, 1);
        add(0, PW1, 1, 1, 8'h41, 1, 1);
        add(0, PW1, 1, 1, 8'h65, 1, 1);
        add(0, PW1, 1, 1, 8'h20, 1, 1);
        add(0, PW1, 1, 1, 8'h7E, 1, 1);
        add(0, PW1, 1, 1, 8'h30, 1, 1);
        add(0, PW1, 1, 1, 8'h0A, 1, 1);
        add(0, PW1, 1, 0, 8'h00, 0, 1);

        // Reset state
        #1;
        chk("rst tx_valid", TX_VALID, 0);
        chk("rst tx_data", TX_DATA, 0);
        chk("rst busy", BUSY, 0);
        chk("rst hit", HIT_CNT, 0);
        chk("rst drop", DROP_CNT, 0);
        chk("rst err", ERR, 0);
        @(negedge CLK);
        RST = 1'b0;

        for (int i = 0; i < n_vec; i++) begin
            @(negedge CLK);
            FOUND = tbl[i].f;
            PASSWD_IN = tbl[i].pw;
            TX_READY = tbl[i].r;
            #1;
            chk($sformatf("row%0d vld", i), TX_VALID, tbl[i].v);
            chk($sformatf("row%0d data", i), TX_DATA, tbl[i].d);
            chk($sformatf("row%0d busy", i), BUSY, tbl[i].b);
            chk($sformatf("row%0d err", i), ERR, tbl[i].e);
        end
        // 5 captures (A..E), 5 drops all in C
        chk("table hit", HIT_CNT, 5);
        chk("table drop", DROP_CNT, 5);
        chk("table hit2 sat", HIT_CNT2, 3);
        chk("table drop2 sat", DROP_CNT2, 3);

        // Reset mid-report while the third byte is stalled
        do_reset();
        FOUND = 1'b1; PASSWD_IN = PW1; TX_READY = 1'b1;
        @(negedge CLK); FOUND = 1'b0;
        @(negedge CLK);
        @(negedge CLK); TX_READY = 1'b0;
        #1;
        chk("pre-abort data", TX_DATA, 8'h20);
        chk("pre-abort hit", HIT_CNT, 1);
        #2 RST = 1'b1;
        #1;
        chk("abort vld", TX_VALID, 0);
        chk("abort data", TX_DATA, 0);
        chk("abort busy", BUSY, 0);
        chk("abort hit", HIT_CNT, 0);
        chk("abort drop", DROP_CNT, 0);
        chk("abort err", ERR, 0);
        @(negedge CLK); RST = 1'b0; TX_READY = 1'b1;
        @(negedge CLK);
        #1;
        chk("no resume vld", TX_VALID, 0);
        FOUND = 1'b1;
        @(negedge CLK); FOUND = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("fresh byte%0d", k), TX_DATA, exp_bytes[k]);
            chk($sformatf("fresh vld%0d", k), TX_VALID, 1);
            @(negedge CLK);
        end
        #1;
        chk("fresh end vld", TX_VALID, 0);
        chk("fresh hit", HIT_CNT, 1);

        // Five separated captures: narrow counter sticks at 3
        do_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK); FOUND = 1'b1; PASSWD_IN = PW2; TX_READY = 1'b1;
            @(negedge CLK); FOUND = 1'b0;
            repeat (6) @(negedge CLK);
        end
        #1;
        chk("sat hit2", HIT_CNT2, 3);
        chk("sat hit", HIT_CNT, 5);
        chk("sat drop", DROP_CNT, 0);
        // Capture plus 4 drops: narrow drop counter also sticks at 3
        @(negedge CLK); FOUND = 1'b1;
        repeat (5) @(negedge CLK);
        FOUND = 1'b0;
        repeat (4) @(negedge CLK);
        #1;
        chk("sat drop2", DROP_CNT2, 3);
        chk("sat drop", DROP_CNT, 4);
        chk("sat hit2 hold", HIT_CNT2, 3);
        chk("sat idle", BUSY, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
